// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared state encoding and size defaults for the ROM loader
package rom_loader_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int ROM_DEPTH_DEF = 32768;
    localparam int DATA_W        = 16;
    localparam int CNT_W         = 16;

    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        CHECK   = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    // States in which the loader is willing to take an upstream byte.
    function automatic logic accepts_byte(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO);
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - byte stream in, ROM write port and CPU control out
//
// slave  : the loader (consumes in_valid/in_data, drives everything else)
// master : the byte source / ROM / Computer side
//   in_valid, in_data  upstream byte and its qualifier
//   in_ready           loader accepts a byte this cycle
//   rom_we             one-cycle write strobe per word
//   rom_addr, rom_data ROM write address and 16-bit instruction
//   cpu_reset          active-high hold-in-reset to the Computer
//   done, error        load finished / illegal length
interface rom_loader_if
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              cpu_reset;
    logic              done;
    logic              error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error
    );
endinterface

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - loads a length-prefixed word stream into the instruction ROM
//
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset; restarts from the length header
//   bus    rom_loader_if.slave: byte stream in, ROM write port, cpu_reset/done/error
//
// Stream format: N (hi, lo) then N words, each hi then lo. Each word costs
// DATA_HI, DATA_LO, WRITE, so a continuously valid source gets one word per
// three cycles.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ROM_DEPTH = ROM_DEPTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    rom_loader_if.slave  bus
);

    state_t             state;
    state_t             state_nx;

    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   counter;
    logic [7:0]         hi_byte;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;

    logic               ready_c;
    logic               take;
    logic               last_word;
    logic               too_long;

    assign last_word = (counter == len - 16'd1);
    // Compare in 32 bits so ROM_DEPTH=65536 style configurations cannot wrap.
    assign too_long  = (32'(len) > 32'(ROM_DEPTH));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LEN_HI;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        ready_c  = accepts_byte(state);
        case (state)
            LEN_HI:  if (bus.in_valid) state_nx = LEN_LO;
            LEN_LO:  if (bus.in_valid) state_nx = CHECK;
            CHECK: begin
                if (len == '0) begin
                    state_nx = DONE;
                end else if (too_long) begin
                    state_nx = ERR;
                end else begin
                    state_nx = DATA_HI;
                end
            end
            DATA_HI: if (bus.in_valid) state_nx = DATA_LO;
            DATA_LO: if (bus.in_valid) state_nx = WRITE;
            WRITE:   state_nx = last_word ? DONE : DATA_HI;
            DONE:    state_nx = DONE;
            ERR:     state_nx = ERR;
            default: state_nx = LEN_HI;
        endcase
    end

    // in_ready is masked by reset so nothing looks acceptable while held.
    assign take = ready_c & reset & bus.in_valid;

    // ------------------------------------------------------------------
    // Byte assembly, word counter and ROM write registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len     <= '0;
            counter <= '0;
            hi_byte <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                LEN_HI:  if (take) len[15:8] <= bus.in_data;
                LEN_LO:  if (take) len[7:0]  <= bus.in_data;
                CHECK:   counter <= '0;
                DATA_HI: if (take) hi_byte <= bus.in_data;
                DATA_LO: begin
                    // Latch address/data on the low byte so they are valid
                    // throughout WRITE and then hold until the next word.
                    if (take) begin
                        addr_q <= counter[ADDR_W-1:0];
                        data_q <= {hi_byte, bus.in_data};
                    end
                end
                WRITE:   if (!last_word) counter <= counter + 16'd1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = ready_c & reset;
    assign bus.rom_we    = (state == WRITE);
    assign bus.rom_addr  = addr_q;
    assign bus.rom_data  = data_q;
    assign bus.cpu_reset = (state != DONE);
    assign bus.done      = (state == DONE);
    assign bus.error     = (state == ERR);

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - randomized self-checking bench for rom_loader
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int SMALL_AW    = 4;
    localparam int SMALL_DEPTH = 16;

    typedef logic [7:0] byte_q_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    always #5 clock = ~clock;

    rom_loader_if                      bus_a ();
    rom_loader_if #(.ADDR_W(SMALL_AW)) bus_b ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in_data  = in_data;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_data  = in_data;

    rom_loader dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    rom_loader #(.ADDR_W(SMALL_AW), .ROM_DEPTH(SMALL_DEPTH)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int sel         = 0;   // 0: observe dut_a, 1: observe small-depth dut_b

    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];

    logic s_ready, s_we, s_done, s_error, s_cpu_reset;
    logic [15:0] s_addr, s_data;

    assign s_ready     = sel ? bus_b.in_ready  : bus_a.in_ready;
    assign s_we        = sel ? bus_b.rom_we    : bus_a.rom_we;
    assign s_done      = sel ? bus_b.done      : bus_a.done;
    assign s_error     = sel ? bus_b.error     : bus_a.error;
    assign s_cpu_reset = sel ? bus_b.cpu_reset : bus_a.cpu_reset;
    assign s_addr      = sel ? 16'(bus_b.rom_addr) : 16'(bus_a.rom_addr);
    assign s_data      = sel ? bus_b.rom_data : bus_a.rom_data;

    always @(posedge clock) cyc++;

    // Write capture plus the status rules that must hold in every cycle.
    always @(negedge clock) begin
        if (s_we) begin
            obs_addr.push_back(int'(s_addr));
            obs_data.push_back(int'(s_data));
            obs_cyc.push_back(cyc);
        end
        vectors++;
        if ((s_cpu_reset !== ~s_done) || (s_done && s_error) || ((s_done || s_error) && s_ready)) begin
            miscompares++;
            $display("FAIL status_rule: done=%b error=%b cpu_reset=%b in_ready=%b at cycle %0d",
                     s_done, s_error, s_cpu_reset, s_ready, cyc);
        end
    end

    function automatic byte_q_t make_stream(input int n, input int words[$]);
        byte_q_t b;
        b.push_back(8'(n >> 8));
        b.push_back(8'(n));
        foreach (words[i]) begin
            b.push_back(8'(words[i] >> 8));
            b.push_back(8'(words[i]));
        end
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // mode 0: valid held, 1: valid toggles each cycle, 2: random valid.
    // stop_writes > 0 abandons the stream once that many writes were seen.
    task automatic send_bytes(input byte_q_t b, input int mode, input int stop_writes);
        int  idx   = 0;
        int  k     = 0;
        logic v;
        while (idx < b.size() && k < 2000) begin
            @(negedge clock);
            if (stop_writes > 0 && obs_addr.size() >= stop_writes) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? b[idx] : 8'($urandom);
            if (v && s_ready) idx++;
            k++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        if (k >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: accepted %0d of %0d bytes", idx, b.size());
        end
    endtask

    task automatic wait_end(output int t_end);
        int k = 0;
        t_end = -1;
        while (k < 40) begin
            if (s_done || s_error) begin
                t_end = cyc;
                break;
            end
            @(negedge clock);
            k++;
        end
        if (t_end < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL end_timeout: done=%b error=%b after %0d cycles", s_done, s_error, k);
        end
    endtask

    task automatic test_reset();
        int w[$];
        sel   = 0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({bus_a.in_ready, bus_a.rom_we, bus_a.rom_addr, bus_a.rom_data, bus_a.cpu_reset, bus_a.done, bus_a.error}
            !== {1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h data=%h cpu_reset=%b done=%b error=%b, want 0 0 0 0 1 0 0",
                     bus_a.in_ready, bus_a.rom_we, bus_a.rom_addr, bus_a.rom_data, bus_a.cpu_reset, bus_a.done, bus_a.error);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus_a.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", bus_a.in_ready);
        end
        // Partial load then reset: ROM write registers must clear.
        w.push_back(16'hBEEF);
        w.push_back(16'h1234);
        send_bytes(make_stream(2, w), 0, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus_a.in_ready, bus_a.rom_we, bus_a.rom_addr, bus_a.rom_data, bus_a.cpu_reset, bus_a.done}
            !== {1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_midload: ready=%b we=%b addr=%h data=%h cpu_reset=%b done=%b",
                     bus_a.in_ready, bus_a.rom_we, bus_a.rom_addr, bus_a.rom_data, bus_a.cpu_reset, bus_a.done);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int w[$];
        int t_end;
        sel = 0;
        do_reset();
        w = '{16'h1122, 16'h3344, 16'h5566};
        send_bytes(make_stream(3, w), 0, 0);
        wait_end(t_end);
        vectors++;
        if (obs_addr.size() != 3) begin
            miscompares++;
            $display("FAIL basic_count: got %0d writes want 3", obs_addr.size());
        end
        foreach (w[i]) if (i < obs_addr.size()) begin
            vectors++;
            if (obs_addr[i] != i || obs_data[i] != w[i]) begin
                miscompares++;
                $display("FAIL basic_write%0d: got %h@%0d want %h@%0d", i, obs_data[i], obs_addr[i], w[i], i);
            end
        end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            vectors++;
            if (obs_cyc[i] - obs_cyc[i-1] != 3) begin
                miscompares++;
                $display("FAIL basic_throughput: write gap %0d want 3", obs_cyc[i] - obs_cyc[i-1]);
            end
        end
        vectors++;
        if (obs_cyc.size() != 3 || t_end != obs_cyc[obs_cyc.size()-1] + 1 || s_done !== 1'b1 || s_cpu_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done: done=%b cpu_reset=%b at cycle %0d, want 1 0 one cycle after last write",
                     s_done, s_cpu_reset, t_end);
        end
    endtask

    task automatic test_zero_len();
        int w[$];
        int t_end;
        sel = 0;
        do_reset();
        send_bytes(make_stream(0, w), 0, 0);
        wait_end(t_end);
        vectors++;
        if (obs_addr.size() != 0 || s_done !== 1'b1 || s_error !== 1'b0 || s_cpu_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len: writes=%0d done=%b error=%b cpu_reset=%b, want 0 1 0 0",
                     obs_addr.size(), s_done, s_error, s_cpu_reset);
        end
    endtask

    task automatic test_error();
        int w[$];
        int t_end;
        sel = 0;
        do_reset();
        send_bytes(make_stream(32769, w), 0, 0);
        wait_end(t_end);
        vectors++;
        if (s_error !== 1'b1 || s_done !== 1'b0 || s_cpu_reset !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL err_state: error=%b done=%b cpu_reset=%b ready=%b, want 1 0 1 0",
                     s_error, s_done, s_cpu_reset, s_ready);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clock);
        in_valid = 1'b0;
        vectors++;
        if (obs_addr.size() != 0 || s_error !== 1'b1) begin
            miscompares++;
            $display("FAIL err_terminal: writes=%0d error=%b, want 0 1", obs_addr.size(), s_error);
        end
    endtask

    task automatic test_toggle();
        int w[$];
        int t_end;
        sel = 0;
        do_reset();
        w = '{int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535))};
        send_bytes(make_stream(2, w), 1, 0);
        wait_end(t_end);
        vectors++;
        if (obs_addr.size() != 2 || s_done !== 1'b1) begin
            miscompares++;
            $display("FAIL toggle_count: writes=%0d done=%b, want 2 1", obs_addr.size(), s_done);
        end
        foreach (w[i]) if (i < obs_addr.size()) begin
            vectors++;
            if (obs_addr[i] != i || obs_data[i] != w[i]) begin
                miscompares++;
                $display("FAIL toggle_write%0d: got %h@%0d want %h@%0d", i, obs_data[i], obs_addr[i], w[i], i);
            end
        end
    endtask

    task automatic test_mid_reset();
        int w[$];
        int t_end;
        sel = 0;
        do_reset();
        w = '{16'h0101, 16'h0202, 16'h0303};
        send_bytes(make_stream(3, w), 0, 1);
        do_reset();
        w = '{16'hABCD};
        send_bytes(make_stream(1, w), 0, 0);
        wait_end(t_end);
        vectors++;
        if (obs_addr.size() != 1 || s_done !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_count: writes=%0d done=%b, want 1 1", obs_addr.size(), s_done);
        end else begin
            vectors++;
            if (obs_addr[0] != 0 || obs_data[0] != 16'hABCD) begin
                miscompares++;
                $display("FAIL midreset_write: got %h@%0d want abcd@0", obs_data[0], obs_addr[0]);
            end
        end
    endtask

    task automatic test_depth_boundary();
        int w[$];
        int t_end;
        sel = 1;
        do_reset();
        for (int i = 0; i < SMALL_DEPTH; i++) w.push_back(int'($urandom_range(0, 65535)));
        send_bytes(make_stream(SMALL_DEPTH, w), 0, 0);
        wait_end(t_end);
        vectors++;
        if (obs_addr.size() != SMALL_DEPTH || s_done !== 1'b1) begin
            miscompares++;
            $display("FAIL depth_full: writes=%0d done=%b, want %0d 1", obs_addr.size(), s_done, SMALL_DEPTH);
        end
        foreach (w[i]) if (i < obs_addr.size()) begin
            vectors++;
            if (obs_addr[i] != i || obs_data[i] != w[i]) begin
                miscompares++;
                $display("FAIL depth_write%0d: got %h@%0d want %h@%0d", i, obs_data[i], obs_addr[i], w[i], i);
            end
        end
        do_reset();
        w.delete();
        send_bytes(make_stream(SMALL_DEPTH + 1, w), 0, 0);
        wait_end(t_end);
        vectors++;
        if (obs_addr.size() != 0 || s_error !== 1'b1 || s_done !== 1'b0) begin
            miscompares++;
            $display("FAIL depth_over: writes=%0d error=%b done=%b, want 0 1 0", obs_addr.size(), s_error, s_done);
        end
        sel = 0;
    endtask

    task automatic test_random();
        int w[$];
        int n;
        int t_end;
        logic want_err;
        sel = 0;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            w.delete();
            if ($urandom_range(0, 3) == 0) begin
                n = int'($urandom_range(ROM_DEPTH_DEF + 1, 65535));
            end else begin
                n = int'($urandom_range(0, 8));
                for (int i = 0; i < n; i++) w.push_back(int'($urandom_range(0, 65535)));
            end
            want_err = (n > ROM_DEPTH_DEF);
            send_bytes(make_stream(n, w), 2, 0);
            wait_end(t_end);
            vectors++;
            if (obs_addr.size() != w.size() || s_error !== want_err || s_done !== !want_err) begin
                miscompares++;
                $display("FAIL rand%0d_end: n=%0d writes=%0d done=%b error=%b, want %0d %b %b",
                         it, n, obs_addr.size(), s_done, s_error, w.size(), !want_err, want_err);
            end
            foreach (w[i]) if (i < obs_addr.size()) begin
                vectors++;
                if (obs_addr[i] != i || obs_data[i] != w[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_write%0d: got %h@%0d want %h@%0d",
                             it, i, obs_data[i], obs_addr[i], w[i], i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_error();
        test_toggle();
        test_mid_reset();
        test_depth_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
